// File: rtl/rr_log_unpacker.sv
// Rebuilds replay records (logb/loge masks plus per-channel payload) from a
// serialized stream of fixed-width log beats: one header beat, then payload beats.
package rr_log_unpacker_pkg;
  // Sum of the first cnt entries of a packed width table with elem_bits-wide entries.
  function automatic int unsigned sum_widths(input logic [1023:0] widths,
                                             input int unsigned  cnt,
                                             input int unsigned  elem_bits);
    logic [1023:0] mask;
    int unsigned   s;
    mask = ~({1024{1'b1}} << elem_bits);
    s    = 0;
    for (int unsigned i = 0; i < cnt; i++) s += 32'((widths >> (i * elem_bits)) & mask);
    return s;
  endfunction
endpackage

module rr_log_unpacker
  import rr_log_unpacker_pkg::*;
#(
  parameter int unsigned RR_CHANNEL_WIDTH_BITS = 32,
  parameter int unsigned AXI_RR_AR_WIDTH       = 100,
  parameter int unsigned AXI_RR_W_WIDTH        = 600,
  parameter int unsigned AXI_RR_AW_WIDTH       = 100,
  parameter int unsigned LOGB_CHANNEL_CNT      = 3,
  parameter int unsigned LOGE_CHANNEL_CNT      = 5,
  parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS = {
    RR_CHANNEL_WIDTH_BITS'(AXI_RR_AR_WIDTH),
    RR_CHANNEL_WIDTH_BITS'(AXI_RR_W_WIDTH),
    RR_CHANNEL_WIDTH_BITS'(AXI_RR_AW_WIDTH)},
  parameter int unsigned IN_WIDTH              = 512,
  localparam int unsigned OUT_W = sum_widths(1024'(CHANNEL_WIDTHS), LOGB_CHANNEL_CNT,
                                             RR_CHANNEL_WIDTH_BITS)
) (
  input  logic                        clk,
  input  logic                        sync_rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_WIDTH-1:0]         in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LOGB_CHANNEL_CNT-1:0] out_logb_valid,
  output logic [LOGE_CHANNEL_CNT-1:0] out_loge_valid,
  output logic [OUT_W-1:0]            out_logb_data,
  output logic [31:0]                 records_out
);

  localparam int unsigned CH_W = (LOGB_CHANNEL_CNT > 1) ? $clog2(LOGB_CHANNEL_CNT) : 1;
  localparam int unsigned EXT_W = OUT_W + IN_WIDTH;

  if (LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT > IN_WIDTH) begin : g_width_check
    $error("rr_log_unpacker: header masks do not fit in IN_WIDTH");
  end

  function automatic int unsigned width_of(input logic [CH_W-1:0] ch);
    return 32'(CHANNEL_WIDTHS[ch]);
  endfunction

  function automatic int unsigned beats_of(input logic [CH_W-1:0] ch);
    return (width_of(ch) + IN_WIDTH - 1) / IN_WIDTH;
  endfunction

  function automatic int unsigned max_beats();
    int unsigned m;
    m = 1;
    for (int unsigned i = 0; i < LOGB_CHANNEL_CNT; i++)
      if (beats_of(i[CH_W-1:0]) > m) m = beats_of(i[CH_W-1:0]);
    return m;
  endfunction

  localparam int unsigned MAX_BEATS = max_beats();
  localparam int unsigned BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  function automatic int unsigned offset_of(input logic [CH_W-1:0] ch);
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < LOGB_CHANNEL_CNT; i++)
      if (i < 32'(ch)) s += width_of(i[CH_W-1:0]);
    return s;
  endfunction

  // Returns {found, index} of the lowest set mask bit at or above start.
  function automatic logic [CH_W:0] find_ch(input logic [LOGB_CHANNEL_CNT-1:0] mask,
                                            input int unsigned start);
    logic [CH_W:0] res;
    res = '0;
    for (int unsigned i = 0; i < LOGB_CHANNEL_CNT; i++)
      if (!res[CH_W] && i >= start && mask[i[CH_W-1:0]]) res = {1'b1, i[CH_W-1:0]};
    return res;
  endfunction

  typedef enum logic [1:0] {ST_HDR, ST_DATA, ST_EMIT} state_t;

  state_t                      r_state;
  logic [CH_W-1:0]             r_ch;
  logic [BEAT_W-1:0]           r_beat;

  logic [LOGB_CHANNEL_CNT-1:0] w_hdr_logb;
  logic [LOGE_CHANNEL_CNT-1:0] w_hdr_loge;
  logic [CH_W:0]               w_first;
  logic [CH_W:0]               w_next;
  logic                        w_last_beat;
  int unsigned                 w_pos;
  logic [OUT_W-1:0]            w_shift;
  logic [OUT_W-1:0]            w_hi_mask;
  logic [OUT_W-1:0]            w_wr;

  always_comb begin
    w_hdr_logb  = in_data[LOGB_CHANNEL_CNT-1:0];
    w_hdr_loge  = in_data[LOGB_CHANNEL_CNT +: LOGE_CHANNEL_CNT];
    w_first     = find_ch(w_hdr_logb, 0);
    w_next      = find_ch(out_logb_valid, 32'(r_ch) + 1);
    w_last_beat = (32'(r_beat) + 1 == beats_of(r_ch));
    // Beat lands at its channel offset; the top mask clips bits past the channel width.
    w_pos       = offset_of(r_ch) + 32'(r_beat) * IN_WIDTH;
    w_shift     = OUT_W'(EXT_W'(in_data) << w_pos);
    w_hi_mask   = ~({OUT_W{1'b1}} << (offset_of(r_ch) + width_of(r_ch)));
    w_wr        = w_shift & w_hi_mask;
  end

  assign in_ready = (r_state != ST_EMIT) && !sync_rst;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_state        <= ST_HDR;
      r_ch           <= '0;
      r_beat         <= '0;
      out_valid      <= 1'b0;
      out_logb_valid <= '0;
      out_loge_valid <= '0;
      out_logb_data  <= '0;
      records_out    <= '0;
    end else begin
      case (r_state)
        ST_HDR: begin
          if (in_valid) begin
            out_logb_valid <= w_hdr_logb;
            out_loge_valid <= w_hdr_loge;
            out_logb_data  <= '0;
            r_beat         <= '0;
            if (w_hdr_logb != '0) begin
              r_ch    <= w_first[CH_W-1:0];
              r_state <= ST_DATA;
            end else if (w_hdr_loge != '0) begin
              out_valid <= 1'b1;
              r_state   <= ST_EMIT;
            end
          end
        end
        ST_DATA: begin
          if (in_valid) begin
            out_logb_data <= out_logb_data | w_wr;
            if (!w_last_beat) begin
              r_beat <= r_beat + 1'b1;
            end else if (w_next[CH_W]) begin
              r_ch   <= w_next[CH_W-1:0];
              r_beat <= '0;
            end else begin
              out_valid <= 1'b1;
              r_state   <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            records_out <= records_out + 32'd1;
            r_state     <= ST_HDR;
          end
        end
        default: r_state <= ST_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_log_unpacker.sv
// Randomized bench for rr_log_unpacker: a record-level model predicts each emitted
// record, its latency and the running record count; directed cases pin the model.
module tb_rr_log_unpacker;
  localparam int unsigned OUT_W = 740;

  logic              clk = 1'b0;
  logic              sync_rst;
  logic              in_valid;
  logic              in_ready;
  logic [511:0]      in_data;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_logb_valid;
  logic [4:0]        out_loge_valid;
  logic [OUT_W-1:0]  out_logb_data;
  logic [31:0]       records_out;

  always #5 clk = ~clk;

  rr_log_unpacker #(
    .LOGB_CHANNEL_CNT(3),
    .LOGE_CHANNEL_CNT(5),
    .CHANNEL_WIDTHS({32'd100, 32'd600, 32'd40}),
    .IN_WIDTH(512)
  ) dut (
    .clk(clk), .sync_rst(sync_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_logb_valid(out_logb_valid), .out_loge_valid(out_loge_valid),
    .out_logb_data(out_logb_data), .records_out(records_out)
  );

  typedef struct {
    logic [2:0]       lb;
    logic [4:0]       le;
    logic [OUT_W-1:0] data;
    int unsigned      cyc;
  } rec_t;

  rec_t         exp_q[$];
  int unsigned  W [3] = '{40, 600, 100};
  logic [511:0] pl [4];
  int unsigned  cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  bit           hold_ready = 1'b0;
  bit           gaps = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [767:0] got, input logic [767:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the beat is taken.
  task automatic send_beat(input logic [511:0] d);
    bit rdy;
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    n        = 0;
    do begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 100);
    if (!rdy) begin
      n_tests++; n_fail++;
      $display("FAIL in_accept_timeout got=in_ready_low exp=accepted_within_100");
    end
    in_valid = 1'b0;
  endtask

  // Sends header plus payload beats pl[] and queues the predicted record.
  task automatic send_record(input logic [2:0] lb, input logic [4:0] le);
    logic [511:0]  hdr;
    logic [1023:0] p;
    rec_t          r;
    int            k;
    int unsigned   off;
    hdr      = rand512();
    hdr[7:0] = {le, lb};
    r.lb = lb; r.le = le; r.data = '0; r.cyc = 0;
    k    = 0;
    off  = 0;
    for (int ch = 0; ch < 3; ch++) begin
      if (lb[ch]) begin
        p = '0;
        for (int b = 0; b < int'((W[ch] + 511) / 512); b++) begin
          p |= 1024'(pl[k]) << (b * 512);
          k++;
        end
        p &= ~({1024{1'b1}} << W[ch]);
        r.data |= OUT_W'(p << off);
      end
      off += W[ch];
    end
    send_beat(hdr);
    for (int j = 0; j < k; j++) send_beat(pl[j]);
    if (lb != 3'b0 || le != 5'b0) begin
      r.cyc = cyc;
      exp_q.push_back(r);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((out_valid || exp_q.size() != 0) && n < 200);
    if (out_valid || exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout got=pending=%0d exp=0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // Compare process: checks every cycle against the record-level model.
  initial begin
    bit          pending;
    bit          rst_prev;
    int unsigned model_cnt;
    pending = 0; rst_prev = 0; model_cnt = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (sync_rst) begin
        chk("in_ready_in_reset", in_ready, 0);
        exp_q.delete();
        pending = 0; model_cnt = 0; rst_prev = 1;
      end else begin
        if (rst_prev) begin
          chk("rst_out_valid", out_valid, 0);
          chk("rst_logb", out_logb_valid, 0);
          chk("rst_loge", out_loge_valid, 0);
          chk("rst_data", out_logb_data, 0);
        end
        rst_prev = 0;
        chk("in_ready", in_ready, !out_valid);
        chk("records_out", records_out, model_cnt);
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_record got=out_valid exp=no_record");
          end else begin
            if (!pending) chk("latency", cyc, exp_q[0].cyc);
            chk("logb", out_logb_valid, exp_q[0].lb);
            chk("loge", out_loge_valid, exp_q[0].le);
            chk("data", out_logb_data, exp_q[0].data);
            pending = 1;
          end
        end
        out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            model_cnt++;
          end
          pending = 0;
        end
      end
    end
  end

  initial begin
    logic [511:0] d0, d1, a, c, hdr;
    sync_rst = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1 sync_rst = 1'b0;

    // Header-only record
    send_record(3'b000, 5'b00001);
    @(negedge clk);
    chk("sc1_valid", out_valid, 1);
    chk("sc1_logb", out_logb_valid, 3'b000);
    chk("sc1_loge", out_loge_valid, 5'b00001);
    chk("sc1_data", out_logb_data, 0);
    @(posedge clk); #1;
    wait_idle();
    chk("sc1_records", records_out, 32'd1);

    // Two-beat channel 1
    d0 = rand512(); d1 = rand512();
    pl[0] = d0; pl[1] = d1;
    send_record(3'b010, 5'b00010);
    @(negedge clk);
    chk("sc2_valid", out_valid, 1);
    chk("sc2_ch1", out_logb_data[639:40], {d1[87:0], d0});
    chk("sc2_ch0_ch2", {out_logb_data[739:640], out_logb_data[39:0]}, 0);
    @(posedge clk); #1;

    // Channels 0 and 2, one beat each, then a header-only record
    a = rand512(); c = rand512();
    pl[0] = a; pl[1] = c;
    send_record(3'b101, 5'b00000);
    @(negedge clk);
    chk("sc3_valid", out_valid, 1);
    chk("sc3_ch0", out_logb_data[39:0], a[39:0]);
    chk("sc3_ch2", out_logb_data[739:640], c[99:0]);
    chk("sc3_ch1", out_logb_data[639:40], 0);
    @(posedge clk); #1;
    send_record(3'b000, 5'b00001);
    wait_idle();
    chk("sc3_records", records_out, 32'd4);

    // Padding header then a real one
    send_record(3'b000, 5'b00000);
    send_record(3'b000, 5'b00001);
    wait_idle();
    chk("sc4_records", records_out, 32'd5);

    // Output backpressure
    d0 = rand512(); d1 = rand512();
    pl[0] = d0; pl[1] = d1;
    hold_ready = 1'b1;
    send_record(3'b010, 5'b00010);
    repeat (5) begin
      @(negedge clk);
      chk("sc5_hold_valid", out_valid, 1);
      chk("sc5_hold_in_ready", in_ready, 0);
      chk("sc5_hold_ch1", out_logb_data[639:40], {d1[87:0], d0});
    end
    hold_ready = 1'b0;
    @(posedge clk); #1;
    send_record(3'b000, 5'b00001);
    wait_idle();
    chk("sc5_records", records_out, 32'd7);

    // Reset mid-record
    hdr = rand512(); hdr[7:0] = 8'h12;
    send_beat(hdr);
    send_beat(rand512());
    sync_rst = 1'b1;
    @(posedge clk); #1;
    sync_rst = 1'b0;
    @(negedge clk);
    chk("sc6_valid", out_valid, 0);
    chk("sc6_records", records_out, 0);
    @(posedge clk); #1;
    send_record(3'b000, 5'b00001);
    @(negedge clk);
    chk("sc6_rec_valid", out_valid, 1);
    chk("sc6_rec_loge", out_loge_valid, 5'b00001);
    @(posedge clk); #1;
    wait_idle();
    chk("sc6_rec_records", records_out, 32'd1);

    // Reset while a record waits in EMIT
    for (int i = 0; i < 4; i++) pl[i] = rand512();
    hold_ready = 1'b1;
    send_record(3'b111, 5'b10101);
    repeat (2) @(posedge clk);
    #1 sync_rst = 1'b1;
    @(posedge clk); #1;
    sync_rst = 1'b0;
    hold_ready = 1'b0;
    @(negedge clk);
    chk("emit_rst_valid", out_valid, 0);
    chk("emit_rst_records", records_out, 0);
    @(posedge clk); #1;

    // Randomized traffic
    gaps = 1'b1;
    repeat (150) begin
      logic [2:0] lb;
      logic [4:0] le;
      lb = 3'($urandom);
      le = 5'($urandom);
      if ($urandom_range(0, 9) == 0) begin lb = '0; le = '0; end
      for (int i = 0; i < 4; i++) pl[i] = rand512();
      send_record(lb, le);
    end
    wait_idle();
    chk("drain_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_log_unpacker.md
# rr_log_unpacker

Reader-side counterpart of the AXI record path. It consumes the serialized log stream that the recorders' logging buses produce once it has been packed into fixed-width beats. It reconstructs one record per log entry: logb valid mask, loge valid mask and per-channel payload. The record is presented on the flat `logb_data` layout that the replay bus and `axichannel_replayer` instances expect. It sits between the replay-buffer DMA reader and the `rr_replay_bus_t` fan-out, one instance per replay bus.

## Interface
Parameters:
- `LOGB_CHANNEL_CNT`, default 3: number of channels carrying payload.
- `LOGE_CHANNEL_CNT`, default 5: number of end-event bits per record.
- `CHANNEL_WIDTHS`, default `{AXI_RR_AR_WIDTH, AXI_RR_W_WIDTH, AXI_RR_AW_WIDTH}`: packed `[LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0]`, payload width per channel, index 0 at LSB.
- `IN_WIDTH`, default 512: log beat width. Must satisfy `LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT <= IN_WIDTH`; violation is a `$error` at elaboration.

Ports:
- `clk`  in  1  the single clock.
- `sync_rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  log beat valid.
- `in_ready`  out  1  log beat accepted when `in_valid && in_ready`.
- `in_data`  in  IN_WIDTH  log beat.
- `out_valid`  out  1  reconstructed record valid.
- `out_ready`  in  1  consumer accepts the record.
- `out_logb_valid`  out  LOGB_CHANNEL_CNT  logb mask of the record.
- `out_loge_valid`  out  LOGE_CHANNEL_CNT  loge mask of the record.
- `out_logb_data`  out  sum(CHANNEL_WIDTHS)  payloads. Channel i occupies `[GET_OFFSET(i) +: CHANNEL_WIDTHS[i]]` (`DEF_GET_OFFSET`).
- `records_out`  out  32  count of emitted records, wraps at 2^32.

## Operation
- Record format on the input stream:
  - Header beat: bits `[LOGB_CHANNEL_CNT-1:0]` are the logb mask; bits `[LOGB_CHANNEL_CNT +: LOGE_CHANNEL_CNT]` are the loge mask; higher bits are ignored.
  - Payload: for each channel i in ascending order with its logb bit set, `ceil(CHANNEL_WIDTHS[i]/IN_WIDTH)` beats follow.
  - Beat k of a channel carries bits `[k*IN_WIDTH +: IN_WIDTH]` of its payload, LSB-aligned. Bits beyond `CHANNEL_WIDTHS[i]` in the last beat are discarded.
- FSM with three states.
  - HDR:
    - On header accept, latch both masks and clear `out_logb_data` to 0.
    - If both masks are zero, the beat is padding: drop it, stay in HDR, produce no output, leave the counter unchanged.
    - Else, if the logb mask is zero, go to EMIT.
    - Else go to DATA at the lowest set channel, beat 0.
  - DATA:
    - Each accepted beat writes the channel slice for the current beat.
    - On the last beat of a channel, advance to the next set channel. If none remains, go to EMIT.
    - Channel index and beat counters are sized `$clog2` of their maxima, minimum width 1.
  - EMIT:
    - `out_valid=1`; all `out_*` held stable.
    - On `out_valid && out_ready`: go to HDR and increment `records_out`.
- Channels whose logb bit is clear output zero payload.
- `in_ready = (state != EMIT)`, forced to 0 while `sync_rst` is high.

## Timing
- Reset: state HDR; `out_valid`, `out_logb_valid`, `out_loge_valid`, `out_logb_data` and `records_out` are all 0; `in_ready` is 0 during reset and 1 the cycle after.
- All outputs except `in_ready` are registered.
- Latency: `out_valid` rises the cycle after the final beat of a record is accepted. For a header-only record, that is the cycle after the header.
- Beats are accepted back-to-back, one per cycle, in HDR and DATA.
- `in_ready` is 0 throughout EMIT. The next header can be accepted no earlier than the cycle after the output handshake, giving one bubble cycle per record.
- Input stall (`in_valid=0`) in DATA: state and partial payload are held indefinitely.
- Output backpressure: EMIT is held and outputs stay bit-stable until `out_ready`.
- Reset mid-record (in DATA or EMIT): the partial or unconsumed record is discarded; the first beat after reset is interpreted as a header.
- `records_out` wraps from 0xFFFFFFFF to 0.

## Test plan
Bench parameters: `IN_WIDTH=512`, `CHANNEL_WIDTHS={100,600,40}` (ch0=40, ch1=600, ch2=100), `LOGE_CHANNEL_CNT=5`.
1. Header with logb=3'b000, loge=5'b00001 -> one cycle later `out_valid=1`, `out_logb_valid=0`, `out_loge_valid=5'b00001`, `out_logb_data` all zero, `records_out=1` after the handshake.
2. Header logb=3'b010, loge=5'b00010, then beats D0 and D1 -> ch1 slice = `{D1[87:0], D0}`; ch0 and ch2 are zero; `out_valid` the cycle after D1.
3. Header logb=3'b101, then beats A and C -> ch0 = `A[39:0]`, ch2 = `C[99:0]`, ch1 = 0; exactly 3 beats consumed.
4. All-zero header followed by a scenario-1 header -> only one `out_valid` pulse; `records_out` increments by 1.
5. Scenario 2 with `out_ready=0` for 5 cycles -> outputs stable, `in_ready=0` throughout; after the handshake, `in_ready=1` the next cycle and the next header is accepted.
6. Scenario 2 header and D0, then `sync_rst` high for 1 cycle -> `out_valid` stays 0 and `records_out=0`; a following scenario-1 record decodes correctly.
